// File: rtl/div_cu.sv
// Moore control unit for the restoring divider: sequences the dp datapath
// (R/X/Y registers, R:X shifter, R-Y mux, iteration counter) from a go/done handshake.
module div_cu #(
    parameter int unsigned N_BITS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic r_lt_y,
    input  logic cnt_out,
    input  logic error,
    output logic ld_r,
    output logic ld_x,
    output logic ld_y,
    output logic sl,
    output logic sr,
    output logic right_in_x,
    output logic sel1,
    output logic sel2,
    output logic ld_cnt,
    output logic ud,
    output logic ce,
    output logic busy,
    output logic done,
    output logic err_out
);

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StChkz,
        StPreshift,
        StTest,
        StSub,
        StShl0,
        StShl1,
        StAdj,
        StDone,
        StErr
    } state_e;

    typedef struct packed {
        logic ld_r;
        logic ld_x;
        logic ld_y;
        logic sl;
        logic sr;
        logic right_in_x;
        logic sel1;
        logic sel2;
        logic ld_cnt;
        logic ce;
        logic busy;
        logic done;
        logic err_out;
    } ctrl_t;

    state_e state_q;
    ctrl_t  ctrl_q;

    // N_BITS only sets the counter load value inside dp; the sequencing is width-independent.
    logic unused_n_bits;
    assign unused_n_bits = ^N_BITS;

    function automatic state_e next_state(input state_e s, input logic g, input logic e,
                                          input logic c, input logic lt);
        state_e n;
        n = StIdle;
        case (s)
            StIdle:     n = g ? StLoad : StIdle;
            StLoad:     n = StChkz;
            StChkz:     n = e ? StErr : StPreshift;
            StPreshift: n = StTest;
            StTest: begin
                if (c)       n = StAdj;
                else if (lt) n = StShl0;
                else         n = StSub;
            end
            StSub:      n = StShl1;
            StShl0:     n = StTest;
            StShl1:     n = StTest;
            StAdj:      n = StDone;
            StDone:     n = StIdle;
            StErr:      n = StIdle;
            default:    n = StIdle;
        endcase
        return n;
    endfunction

    function automatic ctrl_t decode(input state_e s);
        ctrl_t o;
        o = '0;
        o.busy = (s != StIdle);
        case (s)
            StLoad: begin
                o.ld_r   = 1'b1;
                o.ld_x   = 1'b1;
                o.ld_y   = 1'b1;
                o.sel2   = 1'b1;
                o.ld_cnt = 1'b1;
            end
            StPreshift: o.sl = 1'b1;
            StSub: begin
                o.sel1 = 1'b1;
                o.ld_r = 1'b1;
            end
            StShl0: begin
                o.sl = 1'b1;
                o.ce = 1'b1;
            end
            StShl1: begin
                o.sl         = 1'b1;
                o.right_in_x = 1'b1;
                o.ce         = 1'b1;
            end
            StAdj:  o.sr = 1'b1;
            StDone: o.done = 1'b1;
            StErr: begin
                o.done    = 1'b1;
                o.err_out = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

    // Outputs are registered as the decode of the state being entered, so they track state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ctrl_q  <= '0;
        end else begin
            state_q <= next_state(state_q, go, error, cnt_out, r_lt_y);
            ctrl_q  <= decode(next_state(state_q, go, error, cnt_out, r_lt_y));
        end
    end

    assign ld_r       = ctrl_q.ld_r;
    assign ld_x       = ctrl_q.ld_x;
    assign ld_y       = ctrl_q.ld_y;
    assign sl         = ctrl_q.sl;
    assign sr         = ctrl_q.sr;
    assign right_in_x = ctrl_q.right_in_x;
    assign sel1       = ctrl_q.sel1;
    assign sel2       = ctrl_q.sel2;
    assign ld_cnt     = ctrl_q.ld_cnt;
    assign ce         = ctrl_q.ce;
    assign busy       = ctrl_q.busy;
    assign done       = ctrl_q.done;
    assign err_out    = ctrl_q.err_out;
    assign ud         = 1'b0;

endmodule

// File: tb/tb_div_cu.sv
// Directed bench for div_cu driving a behavioural model of the dp datapath;
// checks strobe timing plus the quotient/remainder the datapath ends with.
module tb_div_cu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic go  = 1'b0;
    logic r_lt_y, cnt_out, error;
    logic ld_r, ld_x, ld_y, sl, sr, right_in_x, sel1, sel2, ld_cnt, ud, ce;
    logic busy, done, err_out;

    always #5 clk = ~clk;

    div_cu #(.N_BITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .r_lt_y     (r_lt_y),
        .cnt_out    (cnt_out),
        .error      (error),
        .ld_r       (ld_r),
        .ld_x       (ld_x),
        .ld_y       (ld_y),
        .sl         (sl),
        .sr         (sr),
        .right_in_x (right_in_x),
        .sel1       (sel1),
        .sel2       (sel2),
        .ld_cnt     (ld_cnt),
        .ud         (ud),
        .ce         (ce),
        .busy       (busy),
        .done       (done),
        .err_out    (err_out)
    );

    // Datapath model; R is one bit wider so the pre-subtract shift cannot overflow.
    logic [4:0] r   = '0;
    logic [3:0] x   = '0;
    logic [3:0] y   = '0;
    logic [2:0] cnt = '0;
    logic [3:0] in1 = '0;
    logic [3:0] in2 = '0;

    always_ff @(posedge clk) begin
        if (ld_r)    r <= sel2 ? 5'd0 : (sel1 ? r - {1'b0, y} : r);
        else if (sl) r <= {r[3:0], x[3]};
        else if (sr) r <= r >> 1;
        if (ld_x)    x <= in1;
        else if (sl) x <= {x[2:0], right_in_x};
        if (ld_y)    y <= in2;
        if (ld_cnt)  cnt <= 3'd4;
        else if (ce) cnt <= cnt - 3'd1;
    end

    assign r_lt_y  = (r < {1'b0, y});
    assign cnt_out = (cnt == 3'd0);
    assign error   = (y == 4'd0);

    logic [12:0] ctl_vec;
    assign ctl_vec = {ld_r, ld_x, ld_y, sl, sr, right_in_x, sel1, sel2, ld_cnt, ce,
                      busy, done, err_out};

    localparam logic [12:0] VLoad = 13'b1110000110100;
    localparam logic [12:0] VWait = 13'b0000000000100;
    localparam logic [12:0] VPre  = 13'b0001000000100;
    localparam logic [12:0] VSub  = 13'b1000001000100;
    localparam logic [12:0] VShl1 = 13'b0001010001100;
    localparam logic [12:0] VAdj  = 13'b0000100000100;
    localparam logic [12:0] VDone = 13'b0000000000110;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    int done_cyc, busy_fall, n_sl, n_sr, n_sel1, n_ce, n_done, n_err;
    logic [12:0] trace [0:31];

    // Pulses go in cycle 0 and records cycles 1..24 of the run.
    task automatic run_div(input logic [3:0] a, input logic [3:0] b);
        in1 = a;
        in2 = b;
        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        done_cyc = -1; busy_fall = -1;
        n_sl = 0; n_sr = 0; n_sel1 = 0; n_ce = 0; n_done = 0; n_err = 0;
        for (int c = 1; c <= 24; c++) begin
            trace[c] = ctl_vec;
            if (sl)   n_sl++;
            if (sr)   n_sr++;
            if (sel1) n_sel1++;
            if (ce)   n_ce++;
            if (err_out) n_err++;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (!busy && busy_fall < 0) busy_fall = c;
            @(posedge clk);
            #1;
        end
    endtask

    logic [12:0] exp_tr [1:18];
    int load1, load2, done1, done2;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", {19'd0, ctl_vec}, 32'd0);
        check_eq("ud_const", {31'd0, ud}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("idle_outputs", {19'd0, ctl_vec}, 32'd0);

        // 13 / 3
        run_div(4'd13, 4'd3);
        check_eq("13_3_done_cyc", done_cyc, 15);
        check_eq("13_3_busy_fall", busy_fall, 16);
        check_eq("13_3_done_cnt", n_done, 1);
        check_eq("13_3_sub_cnt", n_sel1, 1);
        check_eq("13_3_sl_cnt", n_sl, 5);
        check_eq("13_3_sr_cnt", n_sr, 1);
        check_eq("13_3_ce_cnt", n_ce, 4);
        check_eq("13_3_quot", {28'd0, x}, 4);
        check_eq("13_3_rem", {27'd0, r}, 1);

        // 15 / 1, full strobe trace
        run_div(4'd15, 4'd1);
        exp_tr[1] = VLoad; exp_tr[2] = VWait; exp_tr[3] = VPre;
        for (int k = 0; k < 4; k++) begin
            exp_tr[4 + 3 * k] = VWait;
            exp_tr[5 + 3 * k] = VSub;
            exp_tr[6 + 3 * k] = VShl1;
        end
        exp_tr[16] = VWait; exp_tr[17] = VAdj; exp_tr[18] = VDone;
        for (int c = 1; c <= 18; c++)
            check_eq($sformatf("15_1_trace_c%0d", c), {19'd0, trace[c]}, {19'd0, exp_tr[c]});
        check_eq("15_1_idle_after", {19'd0, trace[19]}, 32'd0);
        check_eq("15_1_done_cyc", done_cyc, 18);
        check_eq("15_1_quot", {28'd0, x}, 15);
        check_eq("15_1_rem", {27'd0, r}, 0);

        // 0 / 5
        run_div(4'd0, 4'd5);
        check_eq("0_5_done_cyc", done_cyc, 14);
        check_eq("0_5_sel1_cnt", n_sel1, 0);
        check_eq("0_5_quot", {28'd0, x}, 0);
        check_eq("0_5_rem", {27'd0, r}, 0);

        // 7 / 0: divide by zero
        run_div(4'd7, 4'd0);
        check_eq("div0_done_cyc", done_cyc, 3);
        check_eq("div0_err_with_done", {31'd0, trace[3][0]}, 1);
        check_eq("div0_done_cnt", n_done, 1);
        check_eq("div0_err_cnt", n_err, 1);
        check_eq("div0_sl_sr_ce", n_sl + n_sr + n_ce, 0);
        check_eq("div0_busy_fall", busy_fall, 4);

        // Reset mid-run at cycle 6
        in1 = 4'd13; in2 = 4'd3;
        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check_eq("midrst_busy_before", {31'd0, busy}, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("midrst_outputs", {19'd0, ctl_vec}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("midrst_stays_idle", {19'd0, ctl_vec}, 32'd0);
        run_div(4'd9, 4'd2);
        check_eq("9_2_done_cyc", done_cyc, 15);
        check_eq("9_2_quot", {28'd0, x}, 4);
        check_eq("9_2_rem", {27'd0, r}, 1);

        // go held high across back-to-back runs
        in1 = 4'd13; in2 = 4'd3;
        load1 = -1; load2 = -1; done1 = -1; done2 = -1;
        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 35; c++) begin
            if (ld_x) begin
                if (load1 < 0) load1 = c;
                else if (load2 < 0) load2 = c;
            end
            if (done) begin
                if (done1 < 0) done1 = c;
                else if (done2 < 0) done2 = c;
            end
            @(posedge clk);
            #1;
        end
        go = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_eq("hold_load1", load1, 1);
        check_eq("hold_done1", done1, 15);
        check_eq("hold_load2_gap", load2 - done1, 2);
        check_eq("hold_done2", done2, load2 + 14);
        check_eq("hold_final_idle", {31'd0, busy}, 0);
        check_eq("hold_quot", {28'd0, x}, 4);
        check_eq("hold_rem", {27'd0, r}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
